// File: rtl/sweep_ctrl_pkg.sv
// Shared types for the sweep controller: state encoding and default counter width.
// The SWEEP_DWELL_EN macro adds the two endpoint dwell states.
package sweep_pkg;
  localparam int SWEEP_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DOWN     = 3'd2
`ifdef SWEEP_DWELL_EN
    ,S_DWELL_HI = 3'd3,
    S_DWELL_LO = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/status bundle for sweep_ctrl; master drives the run request, slave is the controller.
interface sweep_ctrl_if #(parameter int WIDTH = 16) ();
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [7:0]       n_sweeps;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             tc;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, stop, lo, hi, n_sweeps,
                  input  cnt, dir, tc, busy, done, err);
  modport slave  (input  start, stop, lo, hi, n_sweeps,
                  output cnt, dir, tc, busy, done, err);
endinterface

// File: rtl/sweep_ctrl_updown_cnt.sv
// Loadable up/down counter register; load has priority over counting.
module updown_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
    else if (en)   q <= dir ? q - ONE : q + ONE;
  end
endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep controller: counts lo_q..hi_q..lo_q for n sweeps (0 = forever).
// Define SWEEP_DWELL_EN to hold each endpoint for DWELL extra cycles before reversing.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH = SWEEP_WIDTH,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  sweep_ctrl_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("sweep_ctrl: DWELL must be within 1..255");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo_q, hi_q, cnt_q, ld_val;
  logic [7:0]       n_q, sweeps, sweeps_inc;
  logic             dir_q, done_q, err_q;
  logic             load, en, step_dn, turn_down, bottom, fin;
  logic             start_ok, start_bad;
`ifdef SWEEP_DWELL_EN
  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  logic [7:0] dwell_cnt;
  logic       dwell_ld;
`endif

  assign start_ok   = (state == S_IDLE) && bus.start && (bus.lo < bus.hi);
  assign start_bad  = (state == S_IDLE) && bus.start && !(bus.lo < bus.hi);
  assign sweeps_inc = sweeps + 8'd1;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    en        = 1'b0;
    step_dn   = 1'b0;
    ld_val    = lo_q;
    turn_down = 1'b0;
    bottom    = 1'b0;
    fin       = 1'b0;
`ifdef SWEEP_DWELL_EN
    dwell_ld  = 1'b0;
`endif
    case (state)
      S_IDLE: if (start_ok) begin
        load      = 1'b1;
        ld_val    = bus.lo;
        state_nxt = S_UP;
      end
      S_UP: begin
        if (bus.stop)           state_nxt = S_IDLE;
        else if (cnt_q != hi_q) en = 1'b1;
`ifdef SWEEP_DWELL_EN
        else begin state_nxt = S_DWELL_HI; dwell_ld = 1'b1; end
`else
        else                    turn_down = 1'b1;
`endif
      end
      S_DOWN: begin
        if (bus.stop)           state_nxt = S_IDLE;
        else if (cnt_q != lo_q) begin en = 1'b1; step_dn = 1'b1; end
`ifdef SWEEP_DWELL_EN
        else begin state_nxt = S_DWELL_LO; dwell_ld = 1'b1; end
`else
        else                    bottom = 1'b1;
`endif
      end
`ifdef SWEEP_DWELL_EN
      S_DWELL_HI: begin
        if (bus.stop)               state_nxt = S_IDLE;
        else if (dwell_cnt == 8'd0) turn_down = 1'b1;
      end
      S_DWELL_LO: begin
        if (bus.stop)               state_nxt = S_IDLE;
        else if (dwell_cnt == 8'd0) bottom = 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    // Reversals reload the counter one step inside the bound so no endpoint repeats.
    if (turn_down) begin
      load      = 1'b1;
      ld_val    = hi_q - ONE;
      state_nxt = S_DOWN;
    end
    if (bottom) begin
      if (n_q != 8'd0 && sweeps_inc == n_q) begin
        fin       = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        load      = 1'b1;
        ld_val    = lo_q + ONE;
        state_nxt = S_UP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
      n_q    <= '0;
      sweeps <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= fin;
      err_q  <= start_bad;
      if (start_ok) begin
        lo_q   <= bus.lo;
        hi_q   <= bus.hi;
        n_q    <= bus.n_sweeps;
        sweeps <= '0;
        dir_q  <= 1'b0;
      end
      if (turn_down)        dir_q  <= 1'b1;
      if (bottom && !fin)   dir_q  <= 1'b0;
      if (bottom)           sweeps <= sweeps_inc;
    end
  end

`ifdef SWEEP_DWELL_EN
  always_ff @(posedge clk) begin
    if (rst)                 dwell_cnt <= '0;
    else if (dwell_ld)       dwell_cnt <= DWELL_M1;
    else if (dwell_cnt != 0) dwell_cnt <= dwell_cnt - 8'd1;
  end
`endif

  updown_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (en),
    .dir  (step_dn),
    .d    (ld_val),
    .q    (cnt_q)
  );

  assign bus.cnt  = cnt_q;
  assign bus.dir  = dir_q;
  assign bus.busy = (state != S_IDLE);
  assign bus.tc   = bus.busy && ((!dir_q && cnt_q == hi_q) || (dir_q && cnt_q == lo_q));
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl (default build, no dwell): vector table plus multi-cycle sequences.
module tb_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sweep_ctrl_if #(.WIDTH(16)) bus ();

  sweep_ctrl #(.WIDTH(16), .DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop;
    logic [15:0] lo, hi;
    logic [7:0]  n;
    logic [15:0] cnt;
    logic        dir, busy, done, err, tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic sp, int lo, int hi, int n,
                              int cnt, logic dir, logic busy, logic done, logic err, logic tc);
    vec_t v;
    v.start = st; v.stop = sp; v.lo = 16'(lo); v.hi = 16'(hi); v.n = 8'(n);
    v.cnt = 16'(cnt); v.dir = dir; v.busy = busy; v.done = done; v.err = err; v.tc = tc;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic st, logic sp, int lo, int hi, int n);
    bus.start = st; bus.stop = sp; bus.lo = 16'(lo); bus.hi = 16'(hi); bus.n_sweeps = 8'(n);
  endtask

  task automatic chk_all(string tag, int cnt, logic dir, logic busy, logic done, logic err, logic tc);
    chk({tag, ".cnt"},  int'(bus.cnt),  cnt);
    chk({tag, ".dir"},  int'(bus.dir),  int'(dir));
    chk({tag, ".busy"}, int'(bus.busy), int'(busy));
    chk({tag, ".done"}, int'(bus.done), int'(done));
    chk({tag, ".err"},  int'(bus.err),  int'(err));
    chk({tag, ".tc"},   int'(bus.tc),   int'(tc));
  endtask

  initial begin
    int pat[4];
    pat = '{0, 1, 2, 1};

    //           st sp lo hi n  cnt dir busy done err tc
    tbl.push_back(mk(1, 0, 3, 5, 1, 3, 0, 1, 0, 0, 0));  // 3,4,5,4,3 single sweep
    tbl.push_back(mk(0, 0, 3, 5, 1, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 5, 1, 5, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3, 5, 1, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 5, 1, 3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3, 5, 1, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3, 5, 1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 5, 5, 1, 3, 1, 0, 0, 1, 0));  // lo == hi rejected
    tbl.push_back(mk(0, 0, 5, 5, 1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 7, 2, 1, 3, 1, 0, 0, 1, 0));  // lo > hi rejected
    tbl.push_back(mk(0, 0, 7, 2, 1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 5, 2, 3, 0, 1, 0, 0, 0));  // start beats stop in IDLE
    tbl.push_back(mk(0, 0, 3, 9, 2, 4, 0, 1, 0, 0, 0));  // hi change while busy ignored
    tbl.push_back(mk(0, 0, 3, 9, 2, 5, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 3, 9, 2, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 9, 2, 3, 1, 1, 0, 0, 1));  // start while busy ignored
    tbl.push_back(mk(0, 0, 0, 9, 2, 4, 0, 1, 0, 0, 0));  // first of two sweeps done
    tbl.push_back(mk(0, 1, 0, 9, 2, 4, 0, 0, 0, 0, 0));  // stop: freeze, no done
    tbl.push_back(mk(0, 0, 0, 9, 2, 4, 0, 0, 0, 0, 0));

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].lo, tbl[i].hi, tbl[i].n);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dir, tbl[i].busy,
              tbl[i].done, tbl[i].err, tbl[i].tc);
    end

    // Continuous run 0..2, then stop.
    drive(1, 0, 0, 2, 0);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) step();
      chk($sformatf("cont%0d.cnt", i), int'(bus.cnt), pat[i % 4]);
      chk($sformatf("cont%0d.done", i), int'(bus.done), 0);
    end
    bus.stop = 1'b1;
    step();
    chk("cont_stop.busy", int'(bus.busy), 0);
    chk("cont_stop.cnt", int'(bus.cnt), 1);
    bus.stop = 1'b0;
    step();
    chk("cont_frozen.cnt", int'(bus.cnt), 1);
    chk("cont_frozen.busy", int'(bus.busy), 0);

    // Reset mid-run at cnt=4, with start also high.
    drive(1, 0, 3, 5, 1);
    step();
    bus.start = 1'b0;
    step();
    chk("pre_rst.cnt", int'(bus.cnt), 4);
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    chk_all("post_rst", 0, 0, 0, 0, 0, 0);

    // Stop at the top endpoint wins over reversal.
    drive(1, 0, 3, 5, 1);
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("stop_hi.pre", int'(bus.cnt), 5);
    bus.stop = 1'b1;
    step();
    chk_all("stop_hi", 5, 0, 0, 0, 0, 0);

    // Stop at the bottom of the final sweep suppresses done.
    drive(1, 0, 3, 5, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      bus.start = 1'b0;
    end
    chk("stop_lo.pre", int'(bus.cnt), 3);
    bus.stop = 1'b1;
    step();
    chk_all("stop_lo", 3, 1, 0, 0, 0, 0);
    bus.stop = 1'b0;
    step();
    chk("stop_lo.after_done", int'(bus.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
